// File: rtl/posit_pack_es3.sv
`default_nettype none
// ============================================================================
// Module      : posit_pack_es3
// Description : Four-stage pipelined encoder that turns a raw sum
//               {sgn, scale, fraction, inf, zero} into a 32-bit, es=3 posit.
//               Rounds to nearest, ties to even, and saturates at
//               maxpos/minpos. Reports an inexact flag for each result.
// Revision    : 1.0 - initial release
// ============================================================================
module posit_pack_es3 #(
    parameter int NBITS = 32,
    parameter int ES    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [42:0]      in_sum,
    input  logic             start,
    output logic [NBITS-1:0] result,
    output logic             inexact,
    output logic             done
);

    // maxpos is useed^30 = 2^240, and minpos is 2^-240. Any scale outside
    // this range can only encode to the saturation values.
    localparam logic signed [8:0] c_SCALE_MAX = 9'sd240;
    localparam logic signed [8:0] c_SCALE_MIN = -9'sd240;
    localparam logic [30:0]       c_MAG_MAX   = 31'h7FFF_FFFF;
    // Vector layout: {regime head (2), exponent (ES), fraction (31), 32 zero
    // pad bits}. The pad absorbs the maximum regime shift of 30, so no
    // dropped bit is ever lost before sticky is formed.
    localparam int                c_VW        = 65 + ES;

    // ---------------- Stage 1: capture and clamp ----------------
    logic signed [8:0] w_scale_in;
    logic signed [8:0] w_scale_clamped;
    logic              w_clamp;

    logic              r1_valid;
    logic              r1_sgn;
    logic [8:0]        r1_scale;
    logic [30:0]       r1_frac;
    logic              r1_inf;
    logic              r1_zero;
    logic              r1_clamp;

    // Clamp the incoming scale to the encodable range and remember that we did.
    always_comb begin
        w_scale_in      = $signed(in_sum[41:33]);
        w_scale_clamped = w_scale_in;
        w_clamp         = 1'b0;
        if (w_scale_in > c_SCALE_MAX) begin
            w_scale_clamped = c_SCALE_MAX;
            w_clamp         = 1'b1;
        end else if (w_scale_in < c_SCALE_MIN) begin
            w_scale_clamped = c_SCALE_MIN;
            w_clamp         = 1'b1;
        end
    end

    // Stage 1 register: data is loaded only for valid words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_sgn   <= 1'b0;
            r1_scale <= '0;
            r1_frac  <= '0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_clamp <= 1'b0;
        end else begin
            r1_valid <= start;
            if (start) begin
                r1_sgn   <= in_sum[42];
                r1_scale <= w_scale_clamped;
                r1_frac  <= in_sum[32:2];
                r1_inf   <= in_sum[1];
                r1_zero  <= in_sum[0];
                r1_clamp <= w_clamp;
            end
        end
    end

    // ---------------- Stage 2: regime build and shift ----------------
    logic [8-ES:0]     w_k;
    logic [4:0]        w_sh;
    logic [c_VW-1:0]   w_vec;
    logic [c_VW-1:0]   w_shifted;

    logic              r2_valid;
    logic [30:0]       r2_mag;
    logic              r2_guard;
    logic              r2_sticky;
    logic              r2_sgn;
    logic              r2_inf;
    logic              r2_zero;
    logic              r2_clamp;

    // The regime is built by seeding the vector with {1,0} for k>=0 or
    // {0,1} for k<0. The vector is then arithmetically shifted by k or
    // (-k-1), which replicates the leading bit into the run.
    always_comb begin
        w_k       = r1_scale[8:ES];
        w_sh      = w_k[8-ES] ? ~w_k[4:0] : w_k[4:0];
        w_vec     = {~w_k[8-ES], w_k[8-ES], r1_scale[ES-1:0], r1_frac, 32'd0};
        w_shifted = $signed(w_vec) >>> w_sh;
    end

    // Stage 2 register: the 31 magnitude bits plus the guard and sticky bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid  <= 1'b0;
            r2_mag    <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r2_sgn    <= 1'b0;
            r2_inf    <= 1'b0;
            r2_zero   <= 1'b0;
            r2_clamp  <= 1'b0;
        end else begin
            r2_valid  <= r1_valid;
            r2_mag    <= w_shifted[c_VW-1 -: 31];
            r2_guard  <= w_shifted[c_VW-32];
            r2_sticky <= |w_shifted[c_VW-33:0];
            r2_sgn    <= r1_sgn;
            r2_inf    <= r1_inf;
            r2_zero   <= r1_zero;
            r2_clamp  <= r1_clamp;
        end
    end

    // ---------------- Stage 3: round to nearest even ----------------
    logic              w_inc;
    logic [30:0]       w_mag_rnd;

    logic              r3_valid;
    logic [30:0]       r3_mag;
    logic              r3_inexact;
    logic              r3_sgn;
    logic              r3_inf;
    logic              r3_zero;

    // Increment on guard&(lsb|sticky), but never past maxpos and never to zero.
    always_comb begin
        w_inc     = r2_guard & (r2_mag[0] | r2_sticky) & (r2_mag != c_MAG_MAX);
        w_mag_rnd = r2_mag + {30'd0, w_inc};
        if (w_mag_rnd == 31'd0) begin
            w_mag_rnd = 31'd1;
        end
    end

    // Stage 3 register: the rounded magnitude and the combined inexact flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid   <= 1'b0;
            r3_mag     <= '0;
            r3_inexact <= 1'b0;
            r3_sgn     <= 1'b0;
            r3_inf     <= 1'b0;
            r3_zero    <= 1'b0;
        end else begin
            r3_valid   <= r2_valid;
            r3_mag     <= w_mag_rnd;
            r3_inexact <= r2_guard | r2_sticky | r2_clamp;
            r3_sgn     <= r2_sgn;
            r3_inf     <= r2_inf;
            r3_zero    <= r2_zero;
        end
    end

    // ---------------- Stage 4: sign and specials ----------------
    logic [NBITS-1:0]  w_pos;
    logic [NBITS-1:0]  w_res;
    logic              w_ix;

    // NaR takes priority over zero. Both are exact. Negative results are
    // the two's complement of the encoding.
    always_comb begin
        w_pos = {1'b0, r3_mag};
        w_res = r3_sgn ? (~w_pos + 1'b1) : w_pos;
        w_ix  = r3_inexact;
        if (r3_inf) begin
            w_res = {1'b1, {(NBITS-1){1'b0}}};
            w_ix  = 1'b0;
        end else if (r3_zero) begin
            w_res = '0;
            w_ix  = 1'b0;
        end
    end

    // Output register: result and inexact hold their last value between done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            result  <= '0;
            inexact <= 1'b0;
        end else begin
            done <= r3_valid;
            if (r3_valid) begin
                result  <= w_res;
                inexact <= w_ix;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_pack_es3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_posit_pack_es3
// Description : Directed, table-driven bench for posit_pack_es3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_posit_pack_es3;

    typedef struct packed {
        logic        sgn;
        logic [8:0]  scale;
        logic [30:0] frac;
        logic        inf;
        logic        zero;
        logic [31:0] res;
        logic        ix;
    } vec_t;

    localparam int c_NV = 21;

    logic        clk;
    logic        rst_n;
    logic [42:0] in_sum;
    logic        start;
    logic [31:0] result;
    logic        inexact;
    logic        done;

    vec_t tab [c_NV];
    int   n_total;
    int   n_pass;

    posit_pack_es3 #(.NBITS(32), .ES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_sum  (in_sum),
        .start   (start),
        .result  (result),
        .inexact (inexact),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic s, input logic [8:0] sc, input logic [30:0] f,
                                 input logic inf, input logic z, input logic [31:0] r, input logic x);
        vec_t v;
        v.sgn = s; v.scale = sc; v.frac = f; v.inf = inf; v.zero = z; v.res = r; v.ix = x;
        return v;
    endfunction

    function automatic logic [42:0] pack_in(input vec_t v);
        return {v.sgn, v.scale, v.frac, v.inf, v.zero};
    endfunction

    function automatic logic [42:0] junk();
        return {11'($urandom()), $urandom()};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Inputs already driven; counts edges until done (bounded), then checks latency and data.
    task automatic wait_and_check(input int idx);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (n == 0) begin
                start  = 1'b0;
                in_sum = junk();
            end
            n++;
        end while (done !== 1'b1 && n < 10);
        check($sformatf("vec%0d latency", idx), 32'(n), 32'd4);
        check($sformatf("vec%0d result", idx), result, tab[idx].res);
        check($sformatf("vec%0d inexact", idx), {31'd0, inexact}, {31'd0, tab[idx].ix});
    endtask

    int seq [8];

    initial begin
        n_total = 0;
        n_pass  = 0;
        //                 sgn  scale    frac                      inf   zero  result         ix
        tab[0]  = mkv(1'b0, 9'd0,   31'd0,                     1'b0, 1'b0, 32'h4000_0000, 1'b0);
        tab[1]  = mkv(1'b1, 9'd0,   31'd0,                     1'b0, 1'b0, 32'hC000_0000, 1'b0);
        tab[2]  = mkv(1'b0, 9'd0,   31'h4000_0000,             1'b0, 1'b0, 32'h4200_0000, 1'b0);
        tab[3]  = mkv(1'b0, 9'd8,   31'd0,                     1'b0, 1'b0, 32'h6000_0000, 1'b0);
        tab[4]  = mkv(1'b0, 9'h1FF, 31'd0,                     1'b0, 1'b0, 32'h3C00_0000, 1'b0);
        // largest / smallest 9-bit scales are beyond +/-240 and must saturate
        tab[5]  = mkv(1'b0, 9'h0FF, 31'd0,                     1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
        tab[6]  = mkv(1'b0, 9'h100, 31'd0,                     1'b0, 1'b0, 32'h0000_0001, 1'b1);
        tab[7]  = mkv(1'b0, 9'd0,   31'h0000_0010,             1'b0, 1'b0, 32'h4000_0000, 1'b1);
        tab[8]  = mkv(1'b0, 9'd0,   31'h0000_0030,             1'b0, 1'b0, 32'h4000_0002, 1'b1);
        tab[9]  = mkv(1'b1, 9'd37,  31'h0123_4567,             1'b1, 1'b0, 32'h8000_0000, 1'b0);
        tab[10] = mkv(1'b1, 9'd5,   31'h0000_0007,             1'b0, 1'b1, 32'h0000_0000, 1'b0);
        tab[11] = mkv(1'b0, 9'h1C0, 31'h0000_5555,             1'b1, 1'b1, 32'h8000_0000, 1'b0);
        tab[12] = mkv(1'b0, 9'd240, 31'd0,                     1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0);
        tab[13] = mkv(1'b0, 9'h110, 31'd0,                     1'b0, 1'b0, 32'h0000_0001, 1'b0);
        tab[14] = mkv(1'b1, 9'd8,   31'd0,                     1'b0, 1'b0, 32'hA000_0000, 1'b0);
        tab[15] = mkv(1'b0, 9'd0,   31'h7FFF_FFFF,             1'b0, 1'b0, 32'h4400_0000, 1'b1);
        tab[16] = mkv(1'b0, 9'd241, 31'd0,                     1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1);
        tab[17] = mkv(1'b0, 9'd7,   31'd0,                     1'b0, 1'b0, 32'h5C00_0000, 1'b0);
        tab[18] = mkv(1'b1, 9'd0,   31'h0000_0030,             1'b0, 1'b0, 32'hBFFF_FFFE, 1'b1);
        tab[19] = mkv(1'b0, 9'h138, 31'h4000_0000,             1'b0, 1'b0, 32'h0000_0022, 1'b0);
        tab[20] = mkv(1'b0, 9'h138, 31'h3000_0000,             1'b0, 1'b0, 32'h0000_0022, 1'b1);

        // Reset state
        rst_n  = 1'b0;
        start  = 1'b0;
        in_sum = '0;
        #12;
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset inexact", {31'd0, inexact}, 32'd0);

        // The first start is presented during reset and sampled on the first edge after release.
        in_sum = pack_in(tab[0]);
        start  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_and_check(0);

        // After the pulse, done drops while result holds.
        @(posedge clk); #1;
        check("hold done", {31'd0, done}, 32'd0);
        check("hold result", result, tab[0].res);

        // Single-shot vectors, each followed by junk fields with start low.
        for (int i = 1; i < c_NV; i++) begin
            start  = 1'b1;
            in_sum = pack_in(tab[i]);
            wait_and_check(i);
        end

        // Eight back-to-back starts produce eight consecutive done pulses in order.
        seq = '{2, 5, 6, 8, 9, 10, 15, 20};
        start  = 1'b1;
        in_sum = pack_in(tab[seq[0]]);
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            check($sformatf("b2b done e%0d", e), {31'd0, done}, {31'd0, (e >= 4 && e <= 11)});
            if (e >= 4 && e <= 11) begin
                check($sformatf("b2b result e%0d", e), result, tab[seq[e-4]].res);
                check($sformatf("b2b inexact e%0d", e), {31'd0, inexact}, {31'd0, tab[seq[e-4]].ix});
            end
            if (e < 8) begin
                in_sum = pack_in(tab[seq[e]]);
            end else begin
                start  = 1'b0;
                in_sum = junk();
            end
        end

        // Reset in mid-flight: three words in the pipe, and the first one is
        // already at the output.
        start = 1'b1; in_sum = pack_in(tab[3]);
        @(posedge clk); #1; in_sum = pack_in(tab[4]);
        @(posedge clk); #1; in_sum = pack_in(tab[18]);
        @(posedge clk); #1; start = 1'b0; in_sum = junk();
        @(posedge clk); #1;
        check("pre-reset done", {31'd0, done}, 32'd1);
        check("pre-reset result", result, tab[3].res);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        check("async rst inexact", {31'd0, inexact}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            check($sformatf("post-rst no done e%0d", e), {31'd0, done}, 32'd0);
        end
        start  = 1'b1;
        in_sum = pack_in(tab[16]);
        wait_and_check(16);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
